// File: rtl/can_rec_rr_arbiter.sv
// Round-robin receive arbiter: 32 CAN controllers -> uplink encoder, with stall timeout.
// Define CAN_REC_FIXED_PRIO_EN for fixed priority (lowest enabled index wins).
module can_rec_rr_arbiter #(
    parameter int unsigned N_BUS   = 32,
    parameter int unsigned DATA_W  = 76,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic              clk_40_m,
    input  logic              rst,
    input  logic [4:0]        n_buses,
    input  logic [N_BUS-1:0]  irq_can_rec,
    output logic [N_BUS-1:0]  rec_ack,
    output logic [4:0]        can_rec_select,
    input  logic [DATA_W-1:0] data_rec_in,
    output logic [DATA_W-1:0] data_rec_uplink,
    output logic              uplink_valid,
    input  logic              uplink_ready,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SELECT, CAPTURE, SEND} state_t;

    state_t              state_q, state_d;
    logic [4:0]          ptr_q, ptr_d;
    logic [4:0]          sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic [N_BUS-1:0]    ack_q, ack_d;
    logic                tmo_q, tmo_d;
    logic [15:0]         drop_q, drop_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [N_BUS-1:0]    req;
    logic [4:0]          start, pick, pick_hi, pick_lo, ptr_upd;
    logic                found_hi, found_lo;

    always_comb begin
        for (int unsigned i = 0; i < N_BUS; i++) begin
            req[i] = irq_can_rec[i] && (5'(i) <= n_buses);
        end
    end

    // Two-pass search: first request at/after start, else lowest request (the wrap).
    always_comb begin
        start    = (ptr_q > n_buses) ? '0 : ptr_q;
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int unsigned i = 0; i < N_BUS; i++) begin
            if (req[i] && !found_lo) begin
                found_lo = 1'b1;
                pick_lo  = 5'(i);
            end
            if (req[i] && (5'(i) >= start) && !found_hi) begin
                found_hi = 1'b1;
                pick_hi  = 5'(i);
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

`ifdef CAN_REC_FIXED_PRIO_EN
    assign ptr_upd = '0;
`else
    assign ptr_upd = (sel_q >= n_buses) ? '0 : sel_q + 5'd1;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = '0;
        tmo_d   = 1'b0;
        drop_d  = drop_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    sel_d   = pick;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                state_d = req[sel_q] ? CAPTURE : IDLE;
            end
            CAPTURE: begin
                data_d       = data_rec_in;
                valid_d      = 1'b1;
                ack_d[sel_q] = 1'b1;
                cnt_d        = '0;
                state_d      = SEND;
            end
            SEND: begin
                if (uplink_ready) begin
                    valid_d = 1'b0;
                    ptr_d   = ptr_upd;
                    state_d = IDLE;
                // Counter would reach TIMEOUT on this edge; ready above takes precedence.
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    valid_d = 1'b0;
                    tmo_d   = 1'b1;
                    if (drop_q != '1) drop_d = drop_q + 16'd1;
                    ptr_d   = ptr_upd;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= '0;
            tmo_q   <= 1'b0;
            drop_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            tmo_q   <= tmo_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rec_ack         = ack_q;
    assign can_rec_select  = sel_q;
    assign data_rec_uplink = data_q;
    assign uplink_valid    = valid_q;
    assign busy            = (state_q != IDLE);
    assign timeout_err     = tmo_q;
    assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_can_rec_rr_arbiter.sv
// Bench for can_rec_rr_arbiter: directed steps plus random transactions vs. a grant-order model.
module tb_can_rec_rr_arbiter;

    localparam int TMO = 16;

    logic         clk_40_m = 1'b0;
    logic         rst;
    logic [4:0]   n_buses;
    logic [31:0]  irq_can_rec;
    logic [31:0]  rec_ack;
    logic [4:0]   can_rec_select;
    logic [75:0]  data_rec_in;
    logic [75:0]  data_rec_uplink;
    logic         uplink_valid;
    logic         uplink_ready;
    logic         busy;
    logic         timeout_err;
    logic [15:0]  drop_cnt;

    logic [75:0]  frame_tbl [32];
    int           n_vec = 0;
    int           n_err = 0;
    int           ptr_m = 0;
    int           drops_m = 0;

    can_rec_rr_arbiter #(.N_BUS(32), .DATA_W(76), .TIMEOUT(TMO)) dut (
        .clk_40_m        (clk_40_m),
        .rst             (rst),
        .n_buses         (n_buses),
        .irq_can_rec     (irq_can_rec),
        .rec_ack         (rec_ack),
        .can_rec_select  (can_rec_select),
        .data_rec_in     (data_rec_in),
        .data_rec_uplink (data_rec_uplink),
        .uplink_valid    (uplink_valid),
        .uplink_ready    (uplink_ready),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .drop_cnt        (drop_cnt)
    );

    always #10 clk_40_m = ~clk_40_m;

    // Receive mux of the controllers: the selected bus presents its frame.
    assign data_rec_in = frame_tbl[can_rec_select];

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next grant: scan indices start..n_buses then 0.., modulo the enabled count.
    function automatic int pick_m(input logic [31:0] r, input int n, input int p);
        int s;
        s = (p > n) ? 0 : p;
        for (int k = 0; k <= n; k++) begin
            int idx;
            idx = (s + k) % (n + 1);
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int next_ptr_m(input int served, input int n);
`ifdef CAN_REC_FIXED_PRIO_EN
        return 0;
`else
        return (served >= n) ? 0 : served + 1;
`endif
    endfunction

    // One full transaction; ready is raised d cycles after valid (d >= TMO means never).
    task automatic txn(input int d, input bit clr);
        int          exp_bus, k, exp_k;
        bit          exp_drop;
        logic [31:0] one;
        exp_bus = pick_m(irq_can_rec, int'(n_buses), ptr_m);
        if (exp_bus < 0) begin
            chk("no_request_setup", 80'(0), 80'(1));
            return;
        end
        one = 32'(1) << exp_bus;
        uplink_ready = 1'b0;
        @(posedge clk_40_m); #1;
        chk("select", 80'(can_rec_select), 80'(exp_bus));
        chk("busy_sel", 80'(busy), 80'(1));
        chk("valid_e0", 80'(uplink_valid), 80'(0));
        @(posedge clk_40_m); #1;
        chk("valid_e1", 80'(uplink_valid), 80'(0));
        chk("ack_e1", 80'(rec_ack), 80'(0));
        @(posedge clk_40_m); #1;
        chk("valid_e2", 80'(uplink_valid), 80'(1));
        chk("data", 80'(data_rec_uplink), 80'(frame_tbl[exp_bus]));
        chk("ack_pulse", 80'(rec_ack), 80'(one));
        if (clr) irq_can_rec[exp_bus] = 1'b0;
        uplink_ready = (d == 0);
        k = 0;
        while (uplink_valid && k < TMO + 4) begin
            @(posedge clk_40_m); #1;
            k++;
            if (uplink_valid) begin
                chk("ack_once", 80'(rec_ack), 80'(0));
                chk("select_hold", 80'(can_rec_select), 80'(exp_bus));
            end
            if (k == d) uplink_ready = 1'b1;
        end
        exp_drop = (d > TMO - 1);
        exp_k    = exp_drop ? TMO : d + 1;
        if (exp_drop && drops_m < 65535) drops_m++;
        chk("valid_len", 80'(k), 80'(exp_k));
        chk("timeout_err", 80'(timeout_err), 80'(exp_drop));
        chk("drop_cnt", 80'(drop_cnt), 80'(drops_m));
        chk("busy_end", 80'(busy), 80'(0));
        ptr_m = next_ptr_m(exp_bus, int'(n_buses));
        uplink_ready = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        n_buses      = 5'd31;
        irq_can_rec  = '0;
        uplink_ready = 1'b0;
        for (int i = 0; i < 32; i++) frame_tbl[i] = 76'({$urandom, $urandom, $urandom});
        frame_tbl[5] = 76'h0A5_DEADBEEF_CAFE0123;

        // Reset
        repeat (2) @(posedge clk_40_m);
        #1;
        chk("rst_valid", 80'(uplink_valid), 80'(0));
        chk("rst_select", 80'(can_rec_select), 80'(0));
        chk("rst_data", 80'(data_rec_uplink), 80'(0));
        chk("rst_ack", 80'(rec_ack), 80'(0));
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_tmo", 80'(timeout_err), 80'(0));
        chk("rst_drop", 80'(drop_cnt), 80'(0));
        rst = 1'b1;
        repeat (3) @(posedge clk_40_m);
        #1;
        chk("idle_busy", 80'(busy), 80'(0));
        chk("idle_select", 80'(can_rec_select), 80'(0));

        // Single frame on bus 5, ready held high
        irq_can_rec[5] = 1'b1;
        txn(0, 1'b1);

        // Buses 3 and 7 requesting continuously
        irq_can_rec = (32'(1) << 3) | (32'(1) << 7);
        repeat (4) txn(0, 1'b0);

        // Masking: bus 9 above n_buses is never served
        n_buses     = 5'd4;
        irq_can_rec = (32'(1) << 9) | (32'(1) << 2);
        txn(0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_40_m); #1;
            chk("masked_busy", 80'(busy), 80'(0));
            chk("masked_ack", 80'(rec_ack), 80'(0));
        end

        // Wrap after bus 31
        n_buses     = 5'd31;
        irq_can_rec = 32'(1) << 31;
        txn(1, 1'b1);
        irq_can_rec = (32'(1) << 0) | (32'(1) << 20);
        txn(2, 1'b1);
        irq_can_rec = '0;

        // Timeout drop, then ready on the last possible edge
        irq_can_rec[1] = 1'b1;
        txn(TMO + 10, 1'b1);
        @(posedge clk_40_m); #1;
        chk("tmo_single_pulse", 80'(timeout_err), 80'(0));
        irq_can_rec[1] = 1'b1;
        txn(TMO - 1, 1'b1);

        // Request withdrawn during SELECT
        irq_can_rec = 32'(1) << 2;
        @(posedge clk_40_m); #1;
        chk("wd_select", 80'(can_rec_select), 80'(pick_m(irq_can_rec, 31, ptr_m)));
        irq_can_rec = '0;
        @(posedge clk_40_m); #1;
        chk("wd_busy", 80'(busy), 80'(0));
        chk("wd_ack", 80'(rec_ack), 80'(0));
        chk("wd_valid", 80'(uplink_valid), 80'(0));
        irq_can_rec = (32'(1) << 2) | (32'(1) << 25);
        txn(0, 1'b1);
        irq_can_rec = '0;

        // Random transactions
        for (int t = 0; t < 40; t++) begin
            int          n;
            logic [31:0] m, en;
            n  = int'($urandom_range(0, 31));
            en = (n == 31) ? '1 : ((32'(1) << (n + 1)) - 32'(1));
            m  = $urandom;
            if ((m & en) == '0) m[$urandom_range(0, n)] = 1'b1;
            frame_tbl[$urandom_range(0, 31)] = 76'({$urandom, $urandom, $urandom});
            n_buses     = 5'(n);
            irq_can_rec = m;
            txn(int'($urandom_range(0, TMO + 2)), 1'($urandom_range(0, 1)));
        end
        irq_can_rec = '0;
        n_buses     = 5'd31;

        // Reset while in SEND
        irq_can_rec[4] = 1'b1;
        repeat (3) @(posedge clk_40_m);
        #1;
        chk("pre_rst_valid", 80'(uplink_valid), 80'(1));
        rst = 1'b0;
        @(posedge clk_40_m); #1;
        chk("mid_rst_valid", 80'(uplink_valid), 80'(0));
        chk("mid_rst_select", 80'(can_rec_select), 80'(0));
        chk("mid_rst_drop", 80'(drop_cnt), 80'(0));
        chk("mid_rst_busy", 80'(busy), 80'(0));
        rst         = 1'b1;
        ptr_m       = 0;
        drops_m     = 0;
        irq_can_rec = (32'(1) << 1) | (32'(1) << 30);
        txn(0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
